// File: rtl/pipe_addsub_pkg.sv
// Shared defaults for the pipelined adder/subtractor.
// Also holds a helper that derives the per-stage chunk width.
package pipe_addsub_pkg;

  localparam int ADDSUB_WIDTH  = 16;
  localparam int ADDSUB_STAGES = 4;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/pipe_addsub_chunk.sv
// Combinational C-bit ripple adder used by each pipeline stage.
// It also reports the carry into its MSB, which feeds overflow detection.
module addsub_chunk
  import pipe_addsub_pkg::*;
#(
  parameter int C = chunk_width(ADDSUB_WIDTH, ADDSUB_STAGES)
) (
  input  logic [C-1:0] a,
  input  logic [C-1:0] b,
  input  logic         cin,
  output logic [C-1:0] s,
  output logic         cout,
  output logic         c_msb
);

  logic c;

  always_comb begin
    s     = '0;
    c     = cin;
    c_msb = cin;
    for (int i = 0; i < C; i++) begin
      if (i == C - 1) c_msb = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
    end
    cout = c;
  end

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined two's-complement adder/subtractor, one chunk per stage.
// Valid/ready handshakes on both sides; bubbles collapse and results keep order.
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int WIDTH  = ADDSUB_WIDTH,
  parameter int STAGES = ADDSUB_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int C = chunk_width(WIDTH, STAGES);

  if (WIDTH % STAGES != 0) begin : g_param_check
    $error("pipe_addsub: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
  end

  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] can_load;
  logic [STAGES-1:0] src_valid;
  logic [STAGES-1:0] carry_q;
  logic              msb_carry_q;
  logic [WIDTH-1:0]  acc_q    [STAGES];
  logic [WIDTH-1:0]  opb_q    [STAGES];

  logic [WIDTH-1:0]  acc_in   [STAGES];
  logic [WIDTH-1:0]  opb_in   [STAGES];
  logic [WIDTH-1:0]  acc_next [STAGES];
  logic [STAGES-1:0] carry_in;
  logic [C-1:0]      chunk_sum  [STAGES];
  logic [STAGES-1:0] chunk_cout;
  logic              chunk_cmsb [STAGES];

  // The accumulator word rotates right one chunk per stage: the low chunk is
  // consumed as an operand and the new sum chunk enters at the top, so after
  // the last stage the word holds the complete sum in natural bit order.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign acc_in[k]    = a;
      assign opb_in[k]    = sub ? ~b : b;
      assign carry_in[k]  = sub | cin;
      assign src_valid[k] = in_valid;
    end else begin : g_body
      assign acc_in[k]    = acc_q[k-1];
      assign opb_in[k]    = opb_q[k-1];
      assign carry_in[k]  = carry_q[k-1];
      assign src_valid[k] = stage_valid[k-1];
    end

    addsub_chunk #(.C(C)) u_chunk (
      .a     (acc_in[k][C-1:0]),
      .b     (opb_in[k][C-1:0]),
      .cin   (carry_in[k]),
      .s     (chunk_sum[k]),
      .cout  (chunk_cout[k]),
      .c_msb (chunk_cmsb[k])
    );

    assign acc_next[k] = (acc_in[k] >> C) | (WIDTH'(chunk_sum[k]) << (WIDTH - C));
  end

  // A stage may load when empty or when its occupant moves on this cycle.
  always_comb begin
    can_load = '0;
    can_load[STAGES-1] = !stage_valid[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      can_load[k] = !stage_valid[k] || can_load[k+1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= '0;
      carry_q     <= '0;
      msb_carry_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        acc_q[k] <= '0;
        opb_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (can_load[k]) begin
          stage_valid[k] <= src_valid[k];
          if (src_valid[k]) begin
            acc_q[k]   <= acc_next[k];
            opb_q[k]   <= opb_in[k] >> C;
            carry_q[k] <= chunk_cout[k];
          end
        end
      end
      if (can_load[STAGES-1] && src_valid[STAGES-1]) begin
        msb_carry_q <= chunk_cmsb[STAGES-1];
      end
    end
  end

  assign in_ready  = can_load[0];
  assign out_valid = stage_valid[STAGES-1];
  assign sum       = acc_q[STAGES-1];
  assign cout      = carry_q[STAGES-1];
  assign ovf       = msb_carry_q ^ carry_q[STAGES-1];
  assign zero      = ~|acc_q[STAGES-1];

endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub (16-bit, 4 stages): directed table,
// backpressure and reset sequences, plus a randomized scoreboard run.
module tb_pipe_addsub;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    exp_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;

  int   errors = 0;
  int   checks = 0;
  exp_t model_q[$];
  vec_t vecs[$];

  logic        hold_pending = 1'b0;
  logic [18:0] hold_val = '0;

  pipe_addsub #(.WIDTH(16), .STAGES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the effective operands.
  function automatic exp_t ref_model(input logic [15:0] ra, input logic [15:0] rb,
                                     input logic rcin, input logic rsub);
    exp_t        r;
    logic [15:0] bb;
    int unsigned cc;
    int unsigned total;
    int          sa;
    int          sb;
    int          st;
    bb     = rsub ? ~rb : rb;
    cc     = rsub ? 1 : int'(rcin);
    total  = int'(ra) + int'(bb) + cc;
    r.sum  = total[15:0];
    r.cout = total[16];
    sa     = int'($signed(ra));
    sb     = int'($signed(bb));
    st     = sa + sb + int'(cc);
    r.ovf  = (st > 32767) || (st < -32768);
    r.zero = (r.sum == 16'h0000);
    return r;
  endfunction

  function automatic vec_t mkVec(input logic [15:0] va, input logic [15:0] vb, input logic vcin,
                                 input logic vsub, input logic [15:0] vsum, input logic vcout,
                                 input logic vovf, input logic vzero);
    vec_t v;
    v.a = va; v.b = vb; v.cin = vcin; v.sub = vsub;
    v.exp.sum = vsum; v.exp.cout = vcout; v.exp.ovf = vovf; v.exp.zero = vzero;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] sa, input logic [15:0] sb,
                               input logic scin, input logic ssub);
    a        = sa;
    b        = sb;
    cin      = scin;
    sub      = ssub;
    in_valid = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: transfers are decided by the values held just before each
  // rising edge, so sample on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_q.delete();
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        checkOutput("hold stable", {out_valid, sum, cout, ovf, zero}, {1'b1, hold_val});
      end
      hold_pending = 1'b0;
      if (out_valid && out_ready) begin
        if (model_q.size() == 0) begin
          checkOutput("spurious output", 1, 0);
        end else begin
          exp_t e;
          e = model_q.pop_front();
          checkOutput("scoreboard result", {sum, cout, ovf, zero}, e);
        end
      end else if (out_valid) begin
        hold_pending = 1'b1;
        hold_val     = {sum, cout, ovf, zero};
      end
      if (in_valid && in_ready) begin
        model_q.push_back(ref_model(a, b, cin, sub));
      end
    end
  end

  initial begin
    int lat;
    int nxt;
    int acc;
    int sent;
    int cyc;

    vecs.push_back(mkVec(16'h0003, 16'h0008, 1'b0, 1'b0, 16'h000B, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mkVec(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mkVec(16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mkVec(16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mkVec(16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mkVec(16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mkVec(16'h7FFF, 16'hFFFF, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mkVec(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mkVec(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1));
    vecs.push_back(mkVec(16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mkVec(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mkVec(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0));

    // Reset state
    #12;
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset outputs", {sum, cout, ovf, zero}, {16'h0000, 3'b001});
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checkOutput("in_ready after reset", in_ready, 1);
    tick();

    // Directed table: one operation at a time, latency and result
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      checkOutput($sformatf("vec%0d in_ready", i), in_ready, 1);
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
        tick();
        lat++;
      end
      checkOutput($sformatf("vec%0d latency", i), lat, 3);
      checkOutput($sformatf("vec%0d result", i), {sum, cout, ovf, zero}, vecs[i].exp);
      tick();
    end

    // Backpressure: fill with out_ready low, then drain while refilling
    out_ready = 1'b0;
    nxt = 1;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(16'h0000, 16'(nxt), 1'b0, 1'b0);
      if (in_ready) begin
        acc++;
        nxt++;
      end
      tick();
    end
    in_valid = 1'b0;
    checkOutput("full accept count", acc, 4);
    checkOutput("in_ready when full", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("held result", {out_valid, sum}, {1'b1, 16'h0001});
      tick();
    end
    out_ready = 1'b1;
    #1;
    checkOutput("in_ready while draining", in_ready, 1);
    for (int j = 0; j < 6; j++) begin
      applyStimulus(16'h0000, 16'(nxt), 1'b0, 1'b0);
      #1;
      checkOutput("drain order", {out_valid, sum}, {1'b1, 16'(j + 1)});
      if (in_ready) nxt++;
      tick();
    end
    in_valid = 1'b0;
    cyc = 0;
    while ((out_valid || model_q.size() != 0) && cyc < 30) begin
      tick();
      cyc++;
    end
    checkOutput("backpressure drained", model_q.size(), 0);

    // Random streaming with bubbles and stalls
    sent = 0;
    cyc  = 0;
    while (sent < 200 && cyc < 5000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = 16'($urandom);
      b         = 16'($urandom);
      cin       = 1'($urandom_range(0, 1));
      sub       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
    end
    checkOutput("random ops sent", sent, 200);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while ((out_valid || model_q.size() != 0) && cyc < 50) begin
      tick();
      cyc++;
    end
    checkOutput("random drained", model_q.size(), 0);

    // Mid-operation asynchronous reset
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(16'(16'h1111 * (i + 1)), 16'h0101, 1'b0, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    tick();
    checkOutput("pre-reset out_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid-reset out_valid", out_valid, 0);
    checkOutput("mid-reset outputs", {sum, cout, ovf, zero}, {16'h0000, 3'b001});
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("in_ready after mid reset", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checkOutput("no stale result", out_valid, 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_addsub.md
# pipe_addsub

Parametrised, pipelined two's-complement adder/subtractor with valid/ready handshakes on both sides. Operands are split into `STAGES` equal chunks. Each pipeline stage adds one chunk and passes the carry to the next stage, so the clock period is set by a `WIDTH/STAGES`-bit ripple rather than the full-width ripple. It is the ALU add path for the 16-bit datapath and generalises the 4-bit ripple adder with width, pipelining, subtract mode, flags and backpressure.

## Interface
- `WIDTH`, default 16: operand/result width; must be a multiple of `STAGES`.
- `STAGES`, default 4: pipeline depth and chunk count; 1 ≤ `STAGES` ≤ `WIDTH`.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: operands present.
- `in_ready` output 1: block accepts this cycle.
- `a` input `WIDTH`: operand A.
- `b` input `WIDTH`: operand B.
- `cin` input 1: carry-in, used in add mode only.
- `sub` input 1: 0 = a+b+cin; 1 = a−b, computed as a+~b+1 with `cin` ignored.
- `out_valid` output 1: result present.
- `out_ready` input 1: consumer takes result.
- `sum` output `WIDTH`: result.
- `cout` output 1: carry out of MSB. In subtract mode, 1 means no borrow.
- `ovf` output 1: signed overflow.
- `zero` output 1: `sum` == 0.

## Operation
- Transfer rules:
  - An input transfer occurs when `in_valid && in_ready`.
  - An output transfer occurs when `out_valid && out_ready`.
- Stage 0 captures the full operand set on an input transfer: `a`, `b` (inverted if `sub`), and carry-in = `sub ? 1 : cin`.
- Stage k (0..STAGES−1):
  - Adds chunk k, bits [(k+1)·C−1 : k·C] with C = `WIDTH/STAGES`, using the carry from stage k−1.
  - Stores the sum chunk.
  - Forwards the higher operand chunks, the lower sum chunks and the carry to stage k+1.
- Each stage holds a valid bit. Stage k may load when its register is empty or its contents move on in the same cycle. Bubbles collapse.
- `in_ready` = stage 0 can load. It is combinational from `out_ready` through the valid chain; there is no combinational path from `in_valid` to `in_ready`.
- The last stage drives the outputs:
  - `ovf` = carry into MSB XOR carry out of MSB.
  - `zero` = NOR of the full `sum`, computed from the registered final-stage value.
- Results leave in acceptance order. No drop, no duplication.
- `sum`/flags must hold stable while `out_valid && !out_ready`.
- `STAGES`=1 degenerates to a single registered full-width adder with a 1-entry buffer.

## Timing
- Reset (`rst_n` low, any time, including mid-operation):
  - All valid bits clear immediately, so `out_valid`=0.
  - `in_ready`=1 once `rst_n` is high.
  - `sum`=0, `cout`=0, `ovf`=0, `zero`=1.
  - In-flight operations are discarded.
- Latency: an operation accepted at edge N appears with `out_valid`=1 after edge N+`STAGES−1`, i.e. `STAGES` cycles including the capture cycle, provided the pipeline is not stalled.
- Throughput: one operation per cycle when `out_ready` is held high.
- Full: with `out_ready`=0, exactly `STAGES` operations are accepted. After that, `in_ready`=0.
- Full and draining: when full, raising `out_ready` allows a new input transfer in the same cycle as the output transfer.
- Simultaneous accept on an empty pipeline: the new data enters stage 0 and nothing is emitted that cycle.

## Structure
- Shared package: `ADDSUB_WIDTH`=16 and `ADDSUB_STAGES`=4 defaults, plus a function computing the chunk width (`WIDTH/STAGES`).
- Sub-module `addsub_chunk`: a combinational C-bit ripple adder (parameter C). It returns the chunk sum, carry out, and carry into its MSB (the MSB carry feeds `ovf` in the final chunk). It is instantiated `STAGES` times by a generate loop.
- Top level contains the per-stage registers, the valid/ready chain and the flag logic. Target size is about 150–250 lines.
- Parameter check: elaboration error if `WIDTH % STAGES` ≠ 0.

## Test plan
All scenarios use `WIDTH`=16, `STAGES`=4.
- **Basic add:** a=0x0003, b=0x0008, cin=0, sub=0, `out_ready`=1 → `out_valid` rises 4 cycles after accept; `sum`=0x000B, `cout`=0, `ovf`=0, `zero`=0.
- **Carry across all chunks:** a=0xFFFF, b=0x0001, add → `sum`=0x0000, `cout`=1, `zero`=1, `ovf`=0. Repeat with a=0x00FF, b=0x0000, cin=1 → `sum`=0x0100.
- **Subtract and overflow:**
  - a=0x7FFF, b=0xFFFF, sub=1 → `sum`=0x8000, `ovf`=1, `cout`=0.
  - a=0x0005, b=0x0005, sub=1 → `sum`=0, `zero`=1, `cout`=1.
  - Check that `cin`=1 has no effect in subtract mode.
- **Backpressure:** with `out_ready`=0, stream 0+1, 0+2, … → exactly 4 accepted, then `in_ready`=0 and outputs hold 0x0001 stable. Release `out_ready` → results 1, 2, 3, 4, … in order, one per cycle, nothing lost.
- **Streaming and bubbles:** 200 random operations with random `in_valid`/`out_ready` → every result matches the reference model (sum and all flags) and ordering is preserved.
- **Mid-operation reset:** assert `rst_n`=0 asynchronously with 3 operations in flight → `out_valid`=0 and `sum`=0 immediately. After release, `in_ready`=1 and no stale result appears.
